// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
// Round-robin front end that time-shares one bit-serial adder between two
// requesters. A granted requester's operands are registered onto the adder
// inputs, the adder is started, the fixed adder latency is counted out, and
// the captured sum is returned with a one-cycle done pulse.

module serial_add_arbiter #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 9
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH:0]   sum_out,
    output logic             busy,
    output logic             add_start,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH:0]   add_sum
);

    // Counter is sized for the full legal latency range (1..255).
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [7:0]         r_cnt;
    logic               r_last;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_done0;
    logic               r_done1;
    logic               r_start;
    logic [WIDTH-1:0]   r_add_a;
    logic [WIDTH-1:0]   r_add_b;
    logic               r_add_cin;
    logic [WIDTH:0]     r_sum;

    logic               w_pick0;
    logic               w_pick1;
    logic [7:0]         w_cnt;
    logic               w_last;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_done0;
    logic               w_done1;
    logic               w_start;
    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_cin;
    logic [WIDTH:0]     w_sum;

    // On a tie the requester not served last wins; r_last=1 means 1 went last.
    assign w_pick0 = req0 & (~req1 | r_last);
    assign w_pick1 = req1 & (~req0 | ~r_last);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick0 || w_pick1) begin
                    w_next_state = S_LAUNCH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LAUNCH: w_next_state = S_WAIT;
            S_WAIT: begin
                if (r_cnt == 8'd0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath, decoded per state.
    always_comb begin
        w_cnt     = r_cnt;
        w_last    = r_last;
        w_gnt0    = r_gnt0;
        w_gnt1    = r_gnt1;
        w_done0   = 1'b0;
        w_done1   = 1'b0;
        w_start   = 1'b0;
        w_add_a   = r_add_a;
        w_add_b   = r_add_b;
        w_add_cin = r_add_cin;
        w_sum     = r_sum;
        case (r_state)
            S_IDLE: begin
                if (w_pick0) begin
                    w_gnt0    = 1'b1;
                    w_start   = 1'b1;
                    w_add_a   = a0;
                    w_add_b   = b0;
                    w_add_cin = cin0;
                end else if (w_pick1) begin
                    w_gnt1    = 1'b1;
                    w_start   = 1'b1;
                    w_add_a   = a1;
                    w_add_b   = b1;
                    w_add_cin = cin1;
                end else begin
                    w_start   = 1'b0;
                end
            end
            S_LAUNCH: begin
                w_cnt = CNT_LOAD;
            end
            S_WAIT: begin
                if (r_cnt != 8'd0) begin
                    w_cnt = r_cnt - 8'd1;
                end else begin
                    w_sum   = add_sum;
                    w_done0 = r_gnt0;
                    w_done1 = r_gnt1;
                end
            end
            S_DONE: begin
                w_last = r_gnt1;
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
            default: begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= 8'd0;
            r_last    <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_start   <= 1'b0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_cin <= 1'b0;
            r_sum     <= '0;
        end else begin
            r_cnt     <= w_cnt;
            r_last    <= w_last;
            r_gnt0    <= w_gnt0;
            r_gnt1    <= w_gnt1;
            r_done0   <= w_done0;
            r_done1   <= w_done1;
            r_start   <= w_start;
            r_add_a   <= w_add_a;
            r_add_b   <= w_add_b;
            r_add_cin <= w_add_cin;
            r_sum     <= w_sum;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign add_start = r_start;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_add_cin;
    assign sum_out   = r_sum;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter with a behavioural 9-cycle adder.
module tb_serial_add_arbiter;

    localparam int W = 8;
    localparam int L = 9;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req0, req1, cin0, cin1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1, busy, add_start, add_cin;
    logic [W:0]   sum_out, add_sum;
    logic [W-1:0] add_a, add_b;

    int n_chk  = 0;
    int n_pass = 0;

    int   o_n, o_who, o_starts, o_startk, o_both, o_g1, o_dcnt;
    logic o_cin;

    always #5 clk = ~clk;

    serial_add_arbiter #(.WIDTH(W), .LATENCY(L)) dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .sum_out(sum_out), .busy(busy),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum)
    );

    // Adder model: junk while computing, final sum L cycles after start.
    int m_cnt;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt   <= 0;
            add_sum <= '0;
        end else if (add_start) begin
            m_cnt   <= L - 1;
            add_sum <= 9'h0AA;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) add_sum <= 9'(add_a) + 9'(add_b) + 9'(add_cin);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Follow one operation from the request cycle to its done pulse.
    task automatic run_op(input int chg_at);
        o_n = -1; o_who = -1; o_starts = 0; o_startk = -1;
        o_both = 0; o_g1 = 0; o_cin = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (add_start) begin
                o_starts++;
                o_cin = add_cin;
                if (o_startk < 0) o_startk = k;
            end
            if (gnt0 && gnt1) o_both++;
            if (gnt1) o_g1++;
            if (k == chg_at) a0 = 8'd99;
            if (done0 || done1) begin
                o_n   = k;
                o_who = done1 ? 1 : 0;
                break;
            end
        end
    endtask

    initial begin
        rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
        a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
        do_reset();

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("rst_done", 32'({done0, done1}), 32'd0);
        check("rst_start", 32'(add_start), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);

        // Single operation: 14 + 117 + 0
        a0 = 8'd14; b0 = 8'd117; cin0 = 1'b0; req0 = 1'b1;
        run_op(0);
        check("t1_start_k", 32'(o_startk), 32'd1);
        check("t1_starts", 32'(o_starts), 32'd1);
        check("t1_lat", 32'(o_n), 32'd11);
        check("t1_who", 32'(o_who), 32'd0);
        check("t1_sum", 32'(sum_out), 32'd131);
        check("t1_gnt1", 32'(o_g1), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        check("t1_done_pulse", 32'(done0), 32'd0);
        check("t1_hold_sum", 32'(sum_out), 32'd131);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Carry-in and maximum: 255 + 255 + 1
        a1 = 8'd255; b1 = 8'd255; cin1 = 1'b1; req1 = 1'b1;
        run_op(0);
        check("t2_cin", 32'(o_cin), 32'd1);
        check("t2_who", 32'(o_who), 32'd1);
        check("t2_sum", 32'(sum_out), 32'd511);
        check("t2_lat", 32'(o_n), 32'd11);
        req1 = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: req0 wins the first tie
        do_reset();
        a0 = 8'd200; b0 = 8'd100; cin0 = 1'b1;
        a1 = 8'd5;   b1 = 8'd6;   cin1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        run_op(0);
        check("t3_first", 32'(o_who), 32'd0);
        check("t3_sum0", 32'(sum_out), 32'd301);
        check("t3_lat0", 32'(o_n), 32'd11);
        req0 = 1'b0;
        run_op(0);
        check("t3_second", 32'(o_who), 32'd1);
        check("t3_sum1", 32'(sum_out), 32'd11);
        check("t3_gap", 32'(o_n), 32'd12);
        check("t3_excl", 32'(o_both), 32'd0);
        req1 = 1'b0;
        @(negedge clk);

        // Round-robin fairness under continuous contention
        a0 = 8'd1; b0 = 8'd2; cin0 = 1'b0;
        a1 = 8'd3; b1 = 8'd4; cin1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(0);
            check("rr_who", 32'(o_who), 32'(i % 2));
            check("rr_sum", 32'(sum_out), (i % 2 == 1) ? 32'd7 : 32'd3);
            check("rr_excl", 32'(o_both), 32'd0);
            if (o_who == 1) req1 = 1'b0;
            else req0 = 1'b0;
            @(negedge clk);
            if (i < 3) begin
                req0 = 1'b1; req1 = 1'b1;
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        @(negedge clk);
        check("rr_idle", 32'(busy), 32'd0);

        // Operand change mid-operation has no effect
        do_reset();
        a0 = 8'd14; b0 = 8'd117; cin0 = 1'b0; req0 = 1'b1;
        run_op(4);
        check("t5_sum", 32'(sum_out), 32'd131);
        check("t5_starts", 32'(o_starts), 32'd1);
        check("t5_lat", 32'(o_n), 32'd11);
        req0 = 1'b0;
        @(negedge clk);

        // Reset while the wait counter holds 4
        a0 = 8'd50; b0 = 8'd60; cin0 = 1'b0; req0 = 1'b1;
        for (int k = 1; k <= 6; k++) @(negedge clk);
        check("t6_busy_pre", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("t6_add_a", 32'(add_a), 32'd0);
        check("t6_sum", 32'(sum_out), 32'd0);
        req0 = 1'b0;
        o_dcnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done0 || done1) o_dcnt++;
        end
        check("t6_no_done", 32'(o_dcnt), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        a0 = 8'd1; b0 = 8'd1; cin0 = 1'b0; req0 = 1'b1;
        run_op(0);
        check("t6_who", 32'(o_who), 32'd0);
        check("t6_lat", 32'(o_n), 32'd11);
        check("t6_sum2", 32'(sum_out), 32'd2);
        req0 = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
